// File: rtl/tdm_demux_1x8.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x8
//
// Receive-side TDM demultiplexer. It takes a single-bit serial stream with
// 8 slots per frame; a sync strobe marks slot 0. The bits of one frame are
// collected in a shadow register. When the frame is complete, all eight bits
// are presented together on y1..y8.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   din        in   serial data bit
//   din_valid  in   din/sync are consumed only when high (one slot per cycle)
//   sync       in   marks the current valid bit as slot 0
//   y1..y8     out  registered channel outputs (slot 0 -> y1 ... slot 7 -> y8)
//   s1..s3     out  index of the next slot expected (s1 = MSB)
//   locked     out  high while the receiver is aligned (RUN state)
//   frame_done out  one-cycle pulse, coincident with the y1..y8 update
//   sync_err   out  one-cycle pulse on a framing violation
//
// Parameter:
//   STRICT_SYNC  1: every frame must carry sync on its slot-0 bit.
//                0: frames free-run after the first sync; sync only realigns.
//
// Handshake: a slot is consumed on every rising edge where din_valid is high.
// There is no back-pressure. While din_valid is low, all state holds and no
// pulses are produced.
// ---------------------------------------------------------------------------
module tdm_demux_1x8 #(
   parameter bit STRICT_SYNC = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic din_valid,
   input  logic sync,
   output logic y1,
   output logic y2,
   output logic y3,
   output logic y4,
   output logic y5,
   output logic y6,
   output logic y7,
   output logic y8,
   output logic s1,
   output logic s2,
   output logic s3,
   output logic locked,
   output logic frame_done,
   output logic sync_err
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  slot_q, slot_d;
   // Holds slots 0..6 of the frame being assembled. The slot-7 bit goes
   // straight from din into the output register.
   logic [6:0]  shadow_q, shadow_d;
   logic [7:0]  y_q, y_d;
   logic        frame_done_q, frame_done_d;
   logic        sync_err_q, sync_err_d;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         slot_q       <= 3'd0;
         shadow_q     <= 7'd0;
         y_q          <= 8'd0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         shadow_q     <= shadow_d;
         y_q          <= y_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      shadow_d     = shadow_q;
      y_d          = y_q;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;

      if (din_valid) begin
         case (state_q)
            ST_IDLE: begin
               // Hunt for sync. All other bits are dropped.
               if (sync) begin
                  shadow_d[0] = din;
                  slot_d      = 3'd1;
                  state_d     = ST_RUN;
               end
            end

            ST_RUN: begin
               if (sync) begin
                  // Sync away from slot 0 means misalignment. Drop the
                  // partial frame and realign on this bit at once. This also
                  // covers a sync on slot 7, which is not a completion.
                  sync_err_d  = (slot_q != 3'd0);
                  shadow_d[0] = din;
                  slot_d      = 3'd1;
               end else if (slot_q == 3'd0) begin
                  if (STRICT_SYNC) begin
                     // A missing sync on slot 0 loses lock. The bit is dropped.
                     sync_err_d = 1'b1;
                     state_d    = ST_IDLE;
                  end else begin
                     shadow_d[0] = din;
                     slot_d      = 3'd1;
                  end
               end else if (slot_q == 3'd7) begin
                  // Last slot: publish the whole frame in one step.
                  y_d          = {din, shadow_q};
                  frame_done_d = 1'b1;
                  slot_d       = 3'd0;
               end else begin
                  for (int i = 1; i < 7; i++) begin
                     if (slot_q == 3'(i)) begin
                        shadow_d[i] = din;
                     end
                  end
                  slot_d = slot_q + 3'd1;
               end
            end

            default: begin
               state_d = ST_IDLE;
               slot_d  = 3'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign y1 = y_q[0];
   assign y2 = y_q[1];
   assign y3 = y_q[2];
   assign y4 = y_q[3];
   assign y5 = y_q[4];
   assign y6 = y_q[5];
   assign y7 = y_q[6];
   assign y8 = y_q[7];

   assign s1 = slot_q[2];
   assign s2 = slot_q[1];
   assign s3 = slot_q[0];

   assign locked     = (state_q == ST_RUN);
   assign frame_done = frame_done_q;
   assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1x8
//
// This bench drives two instances from the same stimulus. dut_s uses
// STRICT_SYNC=1 and dut_f uses STRICT_SYNC=0. Each instance has its own
// reset, so only one of them is active at a time. Expected output events
// ({sync_err, frame_done, y8..y1}) are queued by the stimulus. A monitor
// for each instance pops the queue and compares on every output pulse.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1x8;

   localparam logic [1:0] EV_FD  = 2'b01;
   localparam logic [1:0] EV_ERR = 2'b10;

   // Frames: bit k is the slot-k bit, which is also the expected y(k+1).
   localparam logic [7:0] FRAME_A = 8'h4D; // slots 0..7: 1,0,1,1,0,0,1,0
   localparam logic [7:0] FRAME_B = 8'h96; // slots 0..7: 0,1,1,0,1,0,0,1
   localparam logic [7:0] FRAME_C = 8'hA3; // slots 0..7: 1,1,0,0,0,1,0,1

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_s, rst_f;
   logic din, din_valid, sync;

   always #5 clk = ~clk;

   wire [7:0] y_s, y_f;
   wire [2:0] s_s, s_f;
   wire       lk_s, lk_f, fd_s, fd_f, er_s, er_f;

   tdm_demux_1x8 #(.STRICT_SYNC(1'b1)) dut_s (
      .clk(clk), .rst(rst_s), .din(din), .din_valid(din_valid), .sync(sync),
      .y1(y_s[0]), .y2(y_s[1]), .y3(y_s[2]), .y4(y_s[3]),
      .y5(y_s[4]), .y6(y_s[5]), .y7(y_s[6]), .y8(y_s[7]),
      .s1(s_s[2]), .s2(s_s[1]), .s3(s_s[0]),
      .locked(lk_s), .frame_done(fd_s), .sync_err(er_s)
   );

   tdm_demux_1x8 #(.STRICT_SYNC(1'b0)) dut_f (
      .clk(clk), .rst(rst_f), .din(din), .din_valid(din_valid), .sync(sync),
      .y1(y_f[0]), .y2(y_f[1]), .y3(y_f[2]), .y4(y_f[3]),
      .y5(y_f[4]), .y6(y_f[5]), .y7(y_f[6]), .y8(y_f[7]),
      .s1(s_f[2]), .s2(s_f[1]), .s3(s_f[0]),
      .locked(lk_f), .frame_done(fd_f), .sync_err(er_f)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [9:0] exp_s_q[$];
   logic [9:0] exp_f_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [9:0] exp_ev;
      if (fd_s || er_s) begin
         n_tests++;
         if (exp_s_q.size() == 0) begin
            n_fail++;
            $display("FAIL strict_unexpected_event: got %0h expected none", {er_s, fd_s, y_s});
         end else begin
            exp_ev = exp_s_q.pop_front();
            if ({er_s, fd_s, y_s} !== exp_ev) begin
               n_fail++;
               $display("FAIL strict_event: got %0h expected %0h", {er_s, fd_s, y_s}, exp_ev);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [9:0] exp_ev;
      if (fd_f || er_f) begin
         n_tests++;
         if (exp_f_q.size() == 0) begin
            n_fail++;
            $display("FAIL free_unexpected_event: got %0h expected none", {er_f, fd_f, y_f});
         end else begin
            exp_ev = exp_f_q.pop_front();
            if ({er_f, fd_f, y_f} !== exp_ev) begin
               n_fail++;
               $display("FAIL free_event: got %0h expected %0h", {er_f, fd_f, y_f}, exp_ev);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_bit(input logic d, input logic s);
      @(negedge clk);
      din       = d;
      sync      = s;
      din_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         din       = 1'b0;
         sync      = 1'b0;
         din_valid = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] bits, input logic first_sync);
      for (int k = 0; k < 8; k++) begin
         send_bit(bits[k], (k == 0) ? first_sync : 1'b0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_s = 1'b1; rst_f = 1'b1;
      din = 1'b0; din_valid = 1'b0; sync = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("reset_y", {24'd0, y_s}, 32'h0);
      chk("reset_s", {29'd0, s_s}, 32'h0);
      chk("reset_locked", {31'd0, lk_s}, 32'h0);
      chk("reset_pulses", {30'd0, fd_s, er_s}, 32'h0);
      rst_s = 1'b0;
      idle(1);

      // Basic frame
      exp_s_q.push_back({EV_FD, FRAME_A});
      send_frame(FRAME_A, 1'b1);
      idle(1);
      chk("t1_locked", {31'd0, lk_s}, 32'h1);
      chk("t1_s", {29'd0, s_s}, 32'h0);

      // Same frame with gaps after slots 2 and 5
      exp_s_q.push_back({EV_FD, FRAME_A});
      for (int k = 0; k < 8; k++) begin
         send_bit(FRAME_A[k], k == 0);
         if (k == 2 || k == 5) begin
            for (int g = 0; g < 3; g++) begin
               idle(1);
               chk("t2_s_gap", {29'd0, s_s}, (k == 2) ? 32'd3 : 32'd6);
            end
         end
      end
      idle(1);
      chk("t2_fd_latency", {31'd0, fd_s}, 32'h1);
      chk("t2_s_wrap", {29'd0, s_s}, 32'h0);

      // Missing sync on the second frame's slot 0, then relock
      exp_s_q.push_back({EV_FD, FRAME_B});
      exp_s_q.push_back({EV_ERR, FRAME_B});
      send_frame(FRAME_B, 1'b1);
      send_frame(FRAME_C, 1'b0);   // slot 0 errors; the rest is dropped in IDLE
      idle(1);
      chk("t3_unlocked", {31'd0, lk_s}, 32'h0);
      chk("t3_y_held", {24'd0, y_s}, {24'd0, FRAME_B});
      exp_s_q.push_back({EV_FD, FRAME_C});
      send_frame(FRAME_C, 1'b1);
      idle(1);
      chk("t3_relocked", {31'd0, lk_s}, 32'h1);

      // Early sync on slot 4
      exp_s_q.push_back({EV_ERR, FRAME_C});
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);        // becomes the new slot 0
      idle(1);
      chk("t4_s_realign", {29'd0, s_s}, 32'h1);
      chk("t4_locked", {31'd0, lk_s}, 32'h1);
      chk("t4_no_fd", {31'd0, fd_s}, 32'h0);
      exp_s_q.push_back({EV_FD, 8'h9D}); // slots 0..7: 1,0,1,1,1,0,0,1
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      idle(1);

      // Sync on slot 7 is an error, not a completion
      exp_s_q.push_back({EV_ERR, 8'h9D});
      for (int k = 0; k < 7; k++) send_bit(1'b0, k == 0);
      send_bit(1'b1, 1'b1);
      exp_s_q.push_back({EV_FD, 8'hFF});
      for (int k = 0; k < 7; k++) send_bit(1'b1, 1'b0);
      idle(1);
      chk("t4b_y_ones", {24'd0, y_s}, 32'hFF);

      // Reset after slot 5 of a frame
      for (int k = 0; k < 6; k++) send_bit(FRAME_B[k], k == 0);
      @(negedge clk);
      din_valid = 1'b0;
      rst_s     = 1'b1;
      @(negedge clk);
      chk("t6_y_cleared", {24'd0, y_s}, 32'h0);
      chk("t6_s_cleared", {29'd0, s_s}, 32'h0);
      chk("t6_unlocked", {31'd0, lk_s}, 32'h0);
      rst_s = 1'b0;
      send_frame(FRAME_A, 1'b0);
      idle(2);
      chk("t6_still_unlocked", {31'd0, lk_s}, 32'h0);
      chk("t6_y_still_zero", {24'd0, y_s}, 32'h0);

      // Free-running frames, sync on the first only
      rst_s = 1'b1;
      rst_f = 1'b0;
      idle(1);
      exp_f_q.push_back({EV_FD, FRAME_A});
      exp_f_q.push_back({EV_FD, FRAME_B});
      exp_f_q.push_back({EV_FD, FRAME_C});
      send_frame(FRAME_A, 1'b1);
      send_frame(FRAME_B, 1'b0);
      send_frame(FRAME_C, 1'b0);
      idle(1);
      chk("t5_locked", {31'd0, lk_f}, 32'h1);
      chk("t5_y_last", {24'd0, y_f}, {24'd0, FRAME_C});
      idle(3);

      // Every expected event must have been seen
      chk("strict_queue_empty", exp_s_q.size(), 32'd0);
      chk("free_queue_empty", exp_f_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
- Receive-side counterpart of the 8:1 select-driven multiplexer path.
- Takes a single-bit time-division-multiplexed stream, one bit per slot, 8 slots per frame, with slot 0 marked by a sync strobe.
- Distributes each slot's bit to the matching output channel y1..y8.
- Presents all 8 channels together, registered, once per complete frame; flags framing errors.

Parameters:
- STRICT_SYNC, 1: 1 = every frame must start with sync asserted on its slot-0 bit; 0 = after the first sync, frames free-run and sync is needed only to (re)align.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial TDM data bit.
- din_valid  input  1  din (and sync) sampled only when high; one slot consumed per valid cycle.
- sync  input  1  marks the current valid bit as slot 0; ignored when din_valid=0.
- y1, y2, y3, y4, y5, y6, y7, y8  output  1 each  registered channel outputs; slot k-1 maps to yk (slot 0 -> y1, slot 7 -> y8).
- s1, s2, s3  output  1 each  index of the next slot expected; s1 MSB, s3 LSB; matches mux select encoding (000 -> y1 ... 111 -> y8).
- locked  output  1  high in RUN state.
- frame_done  output  1  one-cycle pulse, coincident with the y1..y8 update.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, slot counter=0 (s1..s3=000), shadow register=0.
  - y1..y8=0, locked=0, frame_done=0, sync_err=0.
  - Reset has priority over all other inputs, including mid-frame; a partial frame is discarded and y1..y8 are cleared.
- Cycles with din_valid=0: no state change. Counter, shadow, and y hold; frame_done and sync_err are 0. Gaps are allowed anywhere inside a frame.
- IDLE:
  - Valid bits without sync are discarded.
  - A valid bit with sync=1: the bit is stored as shadow[0], slot becomes 1, state becomes RUN, locked=1 from the next cycle.
- RUN, valid bit at slot n, n = 1..6, sync=0: the bit is stored to shadow[n] and the slot becomes n+1.
- RUN, valid bit at slot 7, sync=0:
  - On the next edge, y1..y8 are loaded with shadow[0..6] plus the current bit, and frame_done=1 for one cycle.
  - Latency is 1 clk from the slot-7 bit to the output.
  - The slot wraps to 0. State stays RUN.
- RUN, valid bit at slot 0:
  - With sync=1: the bit is stored as shadow[0] and the slot becomes 1.
  - With sync=0 and STRICT_SYNC=1: sync_err pulses, state becomes IDLE, locked=0, and the bit is discarded.
  - With sync=0 and STRICT_SYNC=0: treated as the slot-0 data bit, with no error.
- RUN, valid bit at slot n != 0 with sync=1 (early sync / misalignment):
  - sync_err pulses and the partial frame is discarded.
  - y holds its previous value and frame_done=0.
  - The current bit is taken as the new shadow[0], the slot becomes 1, and state stays RUN (immediate realign).
- Output timing:
  - y1..y8 change only together, on a frame_done cycle; they never show a partially filled frame.
  - frame_done and sync_err are never both high; sync_err takes precedence only in the cases above. A slot-7 bit with sync=1 is an early-sync error, not a completion.
- s1..s3 always equal the registered slot counter.

Test Plan:
- Reset, then sync=1 with din sequence 1,0,1,1,0,0,1,0 on 8 consecutive valid cycles -> one cycle after the 8th bit: y1..y8=1,0,1,1,0,0,1,0, frame_done pulses once, locked=1, s=000.
- Same frame with din_valid=0 gaps of 3 cycles inserted after slots 2 and 5 -> identical y values. frame_done is 1 clk after the last valid bit; s holds during the gaps.
- STRICT_SYNC=1, two frames back-to-back where the second frame's slot 0 has sync=0 -> first frame completes; on the second frame's slot 0, sync_err pulses, locked drops, y keeps the first frame's values; a later sync relocks.
- Early sync at slot 4 (sync=1 on the 5th bit) -> sync_err pulse, no frame_done, y unchanged, s=001 next cycle; 7 more valid bits complete a frame with that bit in y1.
- STRICT_SYNC=0, 3 frames with sync only on the first -> 3 frame_done pulses, no sync_err, correct y per frame.
- rst=1 asserted after slot 5 of a frame -> next cycle y=0, s=000, locked=0; 8 valid bits without sync produce no frame_done.
